// File: rtl/arb_pkg.sv
// Shared types for the memory port arbiter.
// Requester count, index type, FSM state and operation encodings.
package arb_pkg;
  localparam int NUM_REQ = 8;
  typedef logic [2:0] req_idx_t;
  typedef enum logic {ARB_IDLE, ARB_ACCESS} arb_state_t;
  typedef enum logic {OP_READ, OP_WRITE} arb_op_t;
endpackage

// File: rtl/mem_port_arbiter_rr_pick8.sv
// rr_pick8: combinational round-robin pick among 8 requests.
// Ports: req_i/ptr_i in; g_o (winning index), valid_o (any request) out.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  req_idx_t           ptr_i,
  output req_idx_t           g_o,
  output logic               valid_o
);
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  req_idx_t             idx;

  // Rotating by ptr puts the highest-priority requester at bit 0.
  assign dbl = {req_i, req_i};
  assign rot = dbl[ptr_i +: NUM_REQ];

  always_comb begin
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) idx = req_idx_t'(i);
    end
  end

  assign g_o     = idx + ptr_i;
  assign valid_o = |req_i;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin owner of the single memory port.
// Ports: clk, rst (async high), req_read/req_write/mem_resp in;
//   sel, mem_read, mem_write, req_resp, busy, timeout_err out.
// Optional macro ARB_TIMEOUT_EN enables the ACCESS abort counter.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter req_idx_t RESET_PRIO     = 3'd0,
  parameter int       TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_read,
  input  logic [NUM_REQ-1:0] req_write,
  input  logic               mem_resp,
  output req_idx_t           sel,
  output logic               mem_read,
  output logic               mem_write,
  output logic [NUM_REQ-1:0] req_resp,
  output logic               busy,
  output logic               timeout_err
);
  arb_state_t state_q, state_d;
  arb_op_t    op_q, op_d;
  req_idx_t   sel_q, sel_d;
  req_idx_t   ptr_q, ptr_d;
  req_idx_t   pick_g;
  logic       pick_v;
  logic       tmo;

  rr_pick8 u_pick (
    .req_i   (req_read | req_write),
    .ptr_i   (ptr_q),
    .g_o     (pick_g),
    .valid_o (pick_v)
  );

`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sel_d    = sel_q;
    ptr_d    = ptr_q;
    req_resp = '0;
    tmo      = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_v) begin
          sel_d   = pick_g;
          op_d    = req_write[pick_g] ? OP_WRITE : OP_READ;
          state_d = ARB_ACCESS;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ARB_ACCESS: begin
        if (mem_resp) begin
          req_resp = NUM_REQ'(1) << sel_q;
          ptr_d    = sel_q + 3'd1;
          state_d  = ARB_IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          tmo     = 1'b1;
          ptr_d   = sel_q + 3'd1;
          state_d = ARB_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      op_q    <= OP_READ;
      sel_q   <= '0;
      ptr_q   <= RESET_PRIO;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

  assign sel         = sel_q;
  assign busy        = (state_q == ARB_ACCESS);
  assign mem_read    = busy && (op_q == OP_READ);
  assign mem_write   = busy && (op_q == OP_WRITE);
  assign timeout_err = tmo;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Build with ARB_TIMEOUT_EN to also cover the abort path.
module tb_mem_port_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_read, req_write, req_resp;
  logic       mem_resp, mem_read, mem_write, busy, timeout_err;
  logic [2:0] sel;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .RESET_PRIO     (3'd0),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_read    (req_read),
    .req_write   (req_write),
    .mem_resp    (mem_resp),
    .sel         (sel),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .req_resp    (req_resp),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input logic [7:0] rd,
                     input logic [7:0] wr,
                     input int g,
                     input bit w,
                     input int lat);
    req_read  = rd;
    req_write = wr;
    step();
    chk("sel", 32'(sel), 32'(g));
    chk("busy", 32'(busy), 1);
    chk("rd", 32'(mem_read), 32'(!w));
    chk("wr", 32'(mem_write), 32'(w));
    for (int i = 1; i < lat; i++) begin
      step();
      chk("rd_hold", 32'(mem_read), 32'(!w));
      chk("sel_hold", 32'(sel), 32'(g));
      chk("resp_idle", 32'(req_resp), 0);
    end
    mem_resp = 1'b1;
    #1;
    chk("resp", 32'(req_resp), 32'(8'h1 << g));
    step();
    mem_resp  = 1'b0;
    req_read  = '0;
    req_write = '0;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_strobe", 32'({mem_read, mem_write}), 0);
    chk("idle_resp", 32'(req_resp), 0);
  endtask

  initial begin
    rst       = 1'b1;
    req_read  = '0;
    req_write = '0;
    mem_resp  = 1'b0;
    step();
    step();
    chk("rst_sel", 32'(sel), 0);
    chk("rst_out", 32'({mem_read, mem_write, busy, timeout_err}), 0);
    chk("rst_resp", 32'(req_resp), 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 9; i++) txn(8'hFF, 8'h00, i % 8, 1'b0, 1);

    txn(8'h04, 8'h00, 2, 1'b0, 3);

    txn(8'h40, 8'h00, 6, 1'b0, 1);
    txn(8'h81, 8'h00, 7, 1'b0, 1);
    txn(8'h81, 8'h00, 0, 1'b0, 1);

    txn(8'h20, 8'h20, 5, 1'b1, 2);
    mem_resp = 1'b1;
    #1;
    chk("idle_mresp", 32'(req_resp), 0);
    step();
    mem_resp = 1'b0;
    chk("idle_stay", 32'(busy), 0);

`ifdef ARB_TIMEOUT_EN
    req_read = 8'h08;
    step();
    req_read = '0;
    chk("to_sel", 32'(sel), 3);
    for (int c = 1; c < 4; c++) begin
      chk("to_early", 32'(timeout_err), 0);
      step();
    end
    chk("to_err", 32'(timeout_err), 1);
    chk("to_resp", 32'(req_resp), 0);
    step();
    chk("to_idle", 32'(busy), 0);
    chk("to_clr", 32'(timeout_err), 0);
`endif

    req_write = 8'h08;
    step();
    req_write = '0;
    chk("pre_rst_wr", 32'(mem_write), 1);
    chk("pre_rst_sel", 32'(sel), 3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_wr", 32'(mem_write), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_sel", 32'(sel), 0);
    step();
    rst = 1'b0;
    step();
    txn(8'h81, 8'h00, 0, 1'b0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
